// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Holds ps2_clock low to inhibit the device, then issues a request-to-send
// (data low, clock released). The device then clocks out the 11-bit frame:
// 8 data bits, odd parity, stop, and finally its own ack bit. Both pins are
// open-drain, so the outputs are "drive low" enables. Incoming pin levels
// are synchronised, and falling edges of the device clock pace the data.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // One shared counter covers the inhibit time and both timeouts. It is
  // sized for the largest of them, so it never wraps.
  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    FAIL
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_reg, bit_next;
  logic [9:0]       frame_reg, frame_next;
  logic             data_oe_reg, data_oe_next;
  logic             ack_reg, ack_next;
  logic             started_reg, started_next;
  logic             clk_prev_reg;

  // Bit 0 is the clock pin and bit 1 is the data pin.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;

  assign pin_raw = {ps2_data_in, ps2_clock_in};

  // Two-flop synchroniser per pin. It resets to 1, which is the idle level
  // of the bus.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      // Bring one raw pin into the clock domain.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  logic clk_sync;
  logic data_sync;
  logic fall_edge;
  logic bus_idle;

  assign clk_sync  = pin_sync[0];
  assign data_sync = pin_sync[1];
  assign fall_edge = clk_prev_reg & ~clk_sync;
  assign bus_idle  = clk_sync & data_sync;

  // Delayed copy of the synchronised clock, used for falling-edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= clk_sync;
    end
  end

  // State register and transfer bookkeeping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      frame_reg   <= '0;
      data_oe_reg <= 1'b0;
      ack_reg     <= 1'b0;
      started_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      frame_reg   <= frame_next;
      data_oe_reg <= data_oe_next;
      ack_reg     <= ack_next;
      started_reg <= started_next;
    end
  end

  // Next-state logic: phase sequencing, bit shifting, ack capture and timeouts.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    frame_next   = frame_reg;
    data_oe_next = data_oe_reg;
    ack_next     = ack_reg;
    started_next = started_reg;

    case (state_reg)
      IDLE: begin
        data_oe_next = 1'b0;
        if (tx_start) begin
          frame_next = {1'b1, ~^tx_data, tx_data};
          cnt_next   = '0;
          state_next = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_reg == INH_LAST) begin
          cnt_next   = '0;
          state_next = REQ;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      REQ: begin
        // The start bit is a driven-low data line. It stays low until
        // the device's first falling edge.
        data_oe_next = 1'b1;
        bit_next     = '0;
        cnt_next     = '0;
        started_next = 1'b0;
        ack_next     = 1'b0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        if (!started_reg) begin
          // Wait for the device to start clocking.
          if (fall_edge) begin
            started_next = 1'b1;
            cnt_next     = CNT_ONE;
            data_oe_next = ~frame_reg[0];
            bit_next     = 4'd1;
          end else if (cnt_reg == START_LAST) begin
            state_next = FAIL;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else if (cnt_reg == XFER_LAST) begin
          state_next = FAIL;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
          if (fall_edge) begin
            if (bit_reg == 4'd10) begin
              // 11th edge: the device answers by holding data low.
              ack_next     = ~data_sync;
              data_oe_next = 1'b0;
              state_next   = WAIT_IDLE;
            end else begin
              data_oe_next = ~frame_reg[bit_reg];
              bit_next     = bit_reg + 4'd1;
            end
          end
        end
      end

      WAIT_IDLE: begin
        data_oe_next = 1'b0;
        if (bus_idle) begin
          state_next = IDLE;
        end else if (cnt_reg == XFER_LAST) begin
          state_next = FAIL;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      FAIL: begin
        data_oe_next = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pin enables and status flags, decoded from state so reset releases
  // the bus at once.
  always_comb begin
    ps2_clock_oe = (state_reg == INHIBIT) || (state_reg == REQ);
    ps2_data_oe  = (state_reg == REQ) || ((state_reg == SHIFT) && data_oe_reg);
    tx_done      = (state_reg == FAIL) || ((state_reg == WAIT_IDLE) && bus_idle);
    tx_error     = (state_reg == FAIL) || ((state_reg == WAIT_IDLE) && bus_idle && ~ack_reg);
    tx_busy      = (state_reg != IDLE) && !tx_done;
  end

endmodule
